truth_sweep_ctrl: RTL and testbench
===================================

// Module: truth_sweep_ctrl
// PURPOSE
//  Sequencer for the 4-input/3-output combinational evaluator (A,B,C,D -> Out_1..Out_3).
//  On start, steps all 16 input vectors (0..15) into the evaluator and waits a settle time.
//  Samples the 3 outputs and compares them against a golden truth table.
//  Reports pass/fail, mismatch count, the first failing vector and the full captured response image.
//  Used as the in-system self-check wrapper around the evaluator.
// PARAMETERS
//  SETTLE        1             settle cycles between vector drive and sample (>=1)
//  GOLDEN        48'hF9AC80B4B980  expected responses; GOLDEN[3*i+:3] = {Out_3,Out_2,Out_1} for vector i
//  STOP_ON_FAIL  0             default stop policy; OR-ed with the stop_on_fail input
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   async active-low reset
//  start         in   1   1-cycle request; accepted only in IDLE or DONE
//  abort         in   1   sync abort; return to IDLE, no done pulse
//  stop_on_fail  in   1   halt at first mismatch (sampled at start acceptance)
//  vec_o         out  4   evaluator inputs; vec_o[3]=A, [2]=B, [1]=C, [0]=D
//  resp_i        in   3   evaluator outputs; [0]=Out_1, [1]=Out_2, [2]=Out_3
//  busy          out  1   high from the cycle after start acceptance until done/abort
//  done          out  1   1-cycle pulse at sweep end (normal end or stop-on-fail)
//  pass          out  1   valid with and after done: err_count==0
//  err_count     out  5   mismatching vectors, 0..16, saturates at 16
//  first_fail    out  4   index of the first mismatching vector
//  ff_vld        out  1   first_fail is valid
//  capture       out  48  sampled responses, same packing as GOLDEN; unswept slots are 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; asserting reset mid-sweep clears everything immediately.
//  States:
//   IDLE -start-> APPLY
//   APPLY: vec_o=idx, cnt counts SETTLE-1..0, then -> SAMPLE
//   SAMPLE: 1 cycle, latch resp_i, compare; then one of:
//    - fail and stop     -> DONE
//    - idx==15           -> DONE
//    - otherwise idx++   -> APPLY
//   DONE: done=1 for exactly 1 cycle, then -> IDLE. Results hold until the next accepted start.
//  Start acceptance clears err_count, ff_vld, first_fail, capture, idx=0, and latches stop policy.
//  Per-vector time = SETTLE+1 cycles. Full sweep: done asserts 16*(SETTLE+1)+1 cycles after start.
//  vec_o changes only on entry to APPLY; it holds the last vector in DONE/IDLE and is 0 after reset.
//  Mismatch: resp_i != GOLDEN[3*idx+:3].
//   - err_count increments (saturates at 16).
//   - On the first mismatch, first_fail=idx and ff_vld=1.
//  Stop-on-fail: DONE on the cycle after the failing SAMPLE; pass=0.
//  Conflicts:
//   - start while busy: ignored.
//   - abort and start in the same cycle: abort wins.
//   - abort in IDLE: no effect.
//   - After abort, results are partial and pass is forced to 0.
//  X on resp_i counts as a mismatch (compare with !==).
// STRUCTURE
//  truth_sweep_pkg holds:
//   - state enum (IDLE, APPLY, SAMPLE, DONE)
//   - NVEC=16, NOUT=3, CAP_W=48
//   - the default GOLDEN constant
//  Sub-module sweep_check: idx-addressed golden lookup, comparator, err/first-fail/capture registers.
//  The top holds the FSM and settle counter.
// TESTING
//  1. Golden evaluator attached, SETTLE=1, start at t0:
//     done at t0+33 cycles; pass=1; err_count=0; ff_vld=0; capture=48'hF9AC80B4B980.
//  2. Out_1 forced stuck-0, stop_on_fail=0:
//     err_count=6 (vectors 4,5,6,7,13,15); first_fail=4; pass=0.
//  3. Same fault, stop_on_fail=1:
//     done after vector 4 (cycle 5*(SETTLE+1)+1); capture[47:15]=0; err_count=1.
//  4. abort at vector 7 mid-APPLY:
//     IDLE next cycle; busy=0; no done pulse; pass=0.
//     A fresh start then gives a full clean sweep.
//  5. rst_n low during SAMPLE of vector 9:
//     all outputs 0 asynchronously.
//     start while busy is ignored: idx sequence unchanged.
//  6. SETTLE=3 with a 2-cycle-delayed golden model:
//     pass=1; done at t0+65.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// ============================================================================
//  Module      : truth_sweep_pkg
//  Description : Shared types and constants for the truth-table sweep
//                self-check (state encoding, vector/response geometry and
//                the default golden response image).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package truth_sweep_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NVEC  = 16;          // number of input vectors swept
    localparam int NOUT  = 3;           // evaluator outputs per vector
    localparam int CAP_W = NVEC * NOUT; // packed response image width

    // Slot i holds {Out_3,Out_2,Out_1} for input vector i
    localparam logic [CAP_W-1:0] DEF_GOLDEN = 48'hF9AC80B4B980;

endpackage

`default_nettype wire

// File: rtl/sweep_check.sv
// ============================================================================
//  Module      : sweep_check
//  Description : Golden lookup, comparator and result registers for the
//                truth-table sweep.
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_clear         clear all results (start accepted)
//                i_sample        record i_resp for vector i_idx this cycle
//                i_idx [3:0]     vector currently applied
//                i_resp [2:0]    evaluator response {Out_3,Out_2,Out_1}
//                o_mismatch      i_resp differs from golden for i_idx
//                o_err_count     mismatching vectors, saturates at 16
//                o_first_fail    index of first mismatching vector
//                o_ff_vld        o_first_fail valid
//                o_capture       packed image of sampled responses
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sweep_check
    import truth_sweep_pkg::*;
#(
    parameter logic [CAP_W-1:0] GOLDEN = DEF_GOLDEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_sample,
    input  logic [3:0]       i_idx,
    input  logic [2:0]       i_resp,
    output logic             o_mismatch,
    output logic [4:0]       o_err_count,
    output logic [3:0]       o_first_fail,
    output logic             o_ff_vld,
    output logic [CAP_W-1:0] o_capture
);

    logic [5:0]       w_base;
    logic [2:0]       w_gold;
    logic [4:0]       r_err_count;
    logic [3:0]       r_first_fail;
    logic             r_ff_vld;
    logic [CAP_W-1:0] r_capture;

    assign w_base = 6'(i_idx) * 6'd3;
    assign w_gold = GOLDEN[w_base +: 3];

    // Case inequality so an undriven/X response is reported as a mismatch
    assign o_mismatch = (i_resp !== w_gold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count  <= 5'd0;
            r_first_fail <= 4'd0;
            r_ff_vld     <= 1'b0;
            r_capture    <= '0;
        end else if (i_clear) begin
            r_err_count  <= 5'd0;
            r_first_fail <= 4'd0;
            r_ff_vld     <= 1'b0;
            r_capture    <= '0;
        end else if (i_sample) begin
            r_capture[w_base +: 3] <= i_resp;
            if (o_mismatch) begin
                if (r_err_count != 5'd16) begin
                    r_err_count <= r_err_count + 5'd1;
                end
                if (!r_ff_vld) begin
                    r_first_fail <= i_idx;
                    r_ff_vld     <= 1'b1;
                end
            end
        end
    end

    assign o_err_count  = r_err_count;
    assign o_first_fail = r_first_fail;
    assign o_ff_vld     = r_ff_vld;
    assign o_capture    = r_capture;

endmodule

`default_nettype wire

// File: rtl/truth_sweep_ctrl.sv
// ============================================================================
//  Module      : truth_sweep_ctrl
//  Description : In-system self-check sequencer for a 4-in/3-out
//                combinational evaluator. Steps vectors 0..15, waits SETTLE
//                cycles, samples and compares against GOLDEN.
//  Ports       : clk, rst_n      clock / async active-low reset
//                start           sweep request (accepted in IDLE or DONE)
//                abort           return to IDLE without a done pulse
//                stop_on_fail    halt on first mismatch (latched at start)
//                vec_o [3:0]     evaluator inputs {A,B,C,D}
//                resp_i [2:0]    evaluator outputs {Out_3,Out_2,Out_1}
//                busy            sweep in progress
//                done            1-cycle end-of-sweep pulse
//                pass            no mismatches (valid with/after done)
//                err_count [4:0] mismatching vectors
//                first_fail[3:0] first mismatching vector, ff_vld valid
//                capture [47:0]  sampled response image
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module truth_sweep_ctrl
    import truth_sweep_pkg::*;
#(
    parameter int               SETTLE       = 1,
    parameter logic [CAP_W-1:0] GOLDEN       = DEF_GOLDEN,
    parameter bit               STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_fail,
    output logic [3:0]       vec_o,
    input  logic [2:0]       resp_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_count,
    output logic [3:0]       first_fail,
    output logic             ff_vld,
    output logic [CAP_W-1:0] capture
);

    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stop;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_accept;
    logic             w_abort;
    logic             w_sample;
    logic             w_mismatch;
    logic             w_pass_next;
    logic [4:0]       w_err_count;

    // Abort beats start; abort only matters while a sweep is running
    assign w_accept = start && !abort &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_abort  = abort &&
                      ((r_state == ST_APPLY) || (r_state == ST_SAMPLE));
    assign w_sample = (r_state == ST_SAMPLE) && !abort;

    // Result of the sweep including the vector being sampled right now
    assign w_pass_next = (w_err_count == 5'd0) && !w_mismatch;

    sweep_check #(
        .GOLDEN (GOLDEN)
    ) u_check (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_accept),
        .i_sample     (w_sample),
        .i_idx        (r_idx),
        .i_resp       (resp_i),
        .o_mismatch   (w_mismatch),
        .o_err_count  (w_err_count),
        .o_first_fail (first_fail),
        .o_ff_vld     (ff_vld),
        .o_capture    (capture)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_accept) begin
                            r_state <= ST_APPLY;
                            r_idx   <= 4'd0;
                            r_cnt   <= CNT_LOAD;
                            r_stop  <= stop_on_fail | STOP_ON_FAIL;
                            r_busy  <= 1'b1;
                            r_pass  <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_APPLY: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        if ((w_mismatch && r_stop) || (r_idx == 4'd15)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= w_pass_next;
                        end else begin
                            // Vector advances only on entry to APPLY
                            r_state <= ST_APPLY;
                            r_idx   <= r_idx + 4'd1;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign vec_o     = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = w_err_count;

endmodule

`default_nettype wire

// File: tb/tb_truth_sweep_ctrl.sv
// ============================================================================
//  Module      : tb_truth_sweep_ctrl
//  Description : Directed self-checking bench for truth_sweep_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_truth_sweep_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Primary DUT, SETTLE=1, combinational evaluator with optional fault
    logic        rst_n, start, abort, stop_on_fail, fault;
    logic [3:0]  vec;
    logic [2:0]  resp, g1;
    logic        busy, done, pass, ff_vld;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic [47:0] cap;

    // Second DUT, SETTLE=3, evaluator delayed by two cycles
    logic        start3;
    logic        abort3 = 1'b0;
    logic        sof3   = 1'b0;
    logic [3:0]  vec3;
    logic [2:0]  d1 = 3'd0, d2 = 3'd0;
    logic        busy3, done3, pass3, ff_vld3;
    logic [4:0]  err3;
    logic [3:0]  ff3;
    logic [47:0] cap3;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc_cnt = 0;

    localparam logic [47:0] GOLD_IMG  = 48'hF9AC80B4B980;
    localparam logic [47:0] STUCK_IMG = 48'hD92C80902980;
    localparam logic [47:0] STOP_IMG  = 48'h000000002980;

    // Hand-decoded golden truth table {Out_3,Out_2,Out_1}
    function automatic logic [2:0] gold(input logic [3:0] v);
        case (v)
            4'd0:  gold = 3'd0;  4'd1:  gold = 3'd0;
            4'd2:  gold = 3'd6;  4'd3:  gold = 3'd4;
            4'd4:  gold = 3'd3;  4'd5:  gold = 3'd1;
            4'd6:  gold = 3'd5;  4'd7:  gold = 3'd5;
            4'd8:  gold = 3'd0;  4'd9:  gold = 3'd0;
            4'd10: gold = 3'd2;  4'd11: gold = 3'd6;
            4'd12: gold = 3'd2;  4'd13: gold = 3'd3;
            4'd14: gold = 3'd6;  default: gold = 3'd7;
        endcase
    endfunction

    assign g1   = gold(vec);
    assign resp = fault ? (g1 & 3'b110) : g1;   // Out_1 stuck at 0

    always @(posedge clk) begin
        d1 <= gold(vec3);
        d2 <= d1;
    end

    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    truth_sweep_ctrl #(.SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stop_on_fail(stop_on_fail), .vec_o(vec), .resp_i(resp),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .first_fail(ff), .ff_vld(ff_vld), .capture(cap)
    );

    truth_sweep_ctrl #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .stop_on_fail(sof3), .vec_o(vec3), .resp_i(d2),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail(ff3), .ff_vld(ff_vld3), .capture(cap3)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the acceptance cycle index; the start cycle itself is cycle 0
    task automatic pulse_start(input logic sof, output int t_acc);
        start        = 1'b1;
        stop_on_fail = sof;
        step();
        start = 1'b0;
        t_acc = cyc_cnt;
    endtask

    // Cycles from the start cycle to the cycle in which done is seen
    task automatic wait_done(input int t_acc, output int cyc);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        cyc = cyc_cnt - t_acc + 1;
        if (done !== 1'b1) begin
            n_vec++;
            n_miss++;
            $error("FAIL done_timeout observed=0 expected=1");
        end
    endtask

    task automatic wait_vec(input logic [3:0] v);
        for (int i = 0; i < 100 && vec !== v; i++) step();
    endtask

    initial begin
        int t0, cyc, seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_on_fail = 1'b0;
        fault = 1'b0; start3 = 1'b0;
        step(); step();

        // Reset state
        chk("rst_vec",   {44'd0, vec}, 48'd0);
        chk("rst_flags", {43'd0, busy, done, pass, ff_vld, 1'b0}, 48'd0);
        chk("rst_err",   {43'd0, err}, 48'd0);
        chk("rst_cap",   cap, 48'd0);
        rst_n = 1'b1;
        step();

        // 1. Clean sweep with golden evaluator
        pulse_start(1'b0, t0);
        chk("t1_busy", {47'd0, busy}, 48'd1);
        wait_done(t0, cyc);
        chk("t1_cycles", cyc, 48'd33);
        chk("t1_pass",   {47'd0, pass}, 48'd1);
        chk("t1_err",    {43'd0, err}, 48'd0);
        chk("t1_ffvld",  {47'd0, ff_vld}, 48'd0);
        chk("t1_cap",    cap, GOLD_IMG);
        chk("t1_vec",    {44'd0, vec}, 48'd15);
        step();
        chk("t1_done_pulse", {47'd0, done}, 48'd0);

        // Abort in IDLE: no effect on results
        abort = 1'b1; step(); abort = 1'b0;
        chk("idle_abort_pass", {47'd0, pass}, 48'd1);
        // Abort and start together: abort wins, start not accepted
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", {47'd0, busy}, 48'd0);
        chk("abort_start_cap",  cap, GOLD_IMG);

        // 2. Out_1 stuck-0, run to completion
        fault = 1'b1;
        pulse_start(1'b0, t0);
        wait_done(t0, cyc);
        chk("t2_cycles", cyc, 48'd33);
        chk("t2_err",    {43'd0, err}, 48'd6);
        chk("t2_ff",     {44'd0, ff}, 48'd4);
        chk("t2_ffvld",  {47'd0, ff_vld}, 48'd1);
        chk("t2_pass",   {47'd0, pass}, 48'd0);
        chk("t2_cap",    cap, STUCK_IMG);

        // 3. Same fault, stop on first fail
        pulse_start(1'b1, t0);
        wait_done(t0, cyc);
        chk("t3_cycles", cyc, 48'd11);
        chk("t3_err",    {43'd0, err}, 48'd1);
        chk("t3_ff",     {44'd0, ff}, 48'd4);
        chk("t3_pass",   {47'd0, pass}, 48'd0);
        chk("t3_cap",    cap, STOP_IMG);
        fault = 1'b0;
        step();

        // 4. Abort while applying vector 7
        pulse_start(1'b0, t0);
        wait_vec(4'd7);
        chk("t4_reach7", {44'd0, vec}, 48'd7);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4_busy", {47'd0, busy}, 48'd0);
        chk("t4_pass", {47'd0, pass}, 48'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen = 1;
            step();
        end
        chk("t4_no_done", seen, 48'd0);
        chk("t4_vec_hold", {44'd0, vec}, 48'd7);
        pulse_start(1'b0, t0);
        wait_done(t0, cyc);
        chk("t4_fresh_cycles", cyc, 48'd33);
        chk("t4_fresh_pass",   {47'd0, pass}, 48'd1);
        chk("t4_fresh_cap",    cap, GOLD_IMG);
        step();

        // Start while busy is ignored: timing and result unchanged
        pulse_start(1'b0, t0);
        wait_vec(4'd3);
        start = 1'b1; step(); start = 1'b0;
        wait_done(t0, cyc);
        chk("busy_start_cycles", cyc, 48'd33);
        chk("busy_start_pass",   {47'd0, pass}, 48'd1);
        step();

        // 5. Reset asserted during SAMPLE of vector 9
        pulse_start(1'b0, t0);
        wait_vec(4'd9);
        step();                 // now in SAMPLE of vector 9
        #2 rst_n = 1'b0;
        #1;
        chk("t5_vec",   {44'd0, vec}, 48'd0);
        chk("t5_flags", {43'd0, busy, done, pass, ff_vld, 1'b0}, 48'd0);
        chk("t5_err",   {43'd0, err}, 48'd0);
        chk("t5_cap",   cap, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t5_idle", {47'd0, busy}, 48'd0);

        // 6. SETTLE=3 with two-cycle evaluator latency
        start3 = 1'b1; step(); start3 = 1'b0;
        t0 = cyc_cnt;
        for (int i = 0; i < 300 && done3 !== 1'b1; i++) step();
        chk("t6_done",   {47'd0, done3}, 48'd1);
        chk("t6_cycles", cyc_cnt - t0 + 1, 48'd65);
        chk("t6_pass",   {47'd0, pass3}, 48'd1);
        chk("t6_err",    {43'd0, err3}, 48'd0);
        chk("t6_cap",    cap3, GOLD_IMG);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
